// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load size encodings,
// register file geometry, the queued write request and load extension.
package wb_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  localparam int WB_DATA_WIDTH  = 64;

  typedef enum logic [1:0] {
    LD_BYTE   = 2'b00,
    LD_HALF   = 2'b01,
    LD_WORD   = 2'b10,
    LD_DOUBLE = 2'b11
  } ld_size_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]  data;
  } wb_req_t;

  // Pick the low byte/half/word/double of a right-aligned load and fill the
  // upper bits with zeros or with copies of the top bit that was taken.
  // A double has no upper bits, so the unsigned flag has no effect on it.
  function automatic logic [WB_DATA_WIDTH-1:0] extend_load(
    input logic [WB_DATA_WIDTH-1:0] raw,
    input logic [1:0]               size,
    input logic                     is_unsigned
  );
    logic [WB_DATA_WIDTH-1:0] result;
    logic                     fill;
    result = raw;
    fill   = 1'b0;
    case (ld_size_e'(size))
      LD_BYTE: begin
        fill   = ~is_unsigned & raw[7];
        result = {{(WB_DATA_WIDTH-8){fill}}, raw[7:0]};
      end
      LD_HALF: begin
        fill   = ~is_unsigned & raw[15];
        result = {{(WB_DATA_WIDTH-16){fill}}, raw[15:0]};
      end
      LD_WORD: begin
        fill   = ~is_unsigned & raw[31];
        result = {{(WB_DATA_WIDTH-32){fill}}, raw[31:0]};
      end
      default: begin
        result = raw;
      end
    endcase
    return result;
  endfunction

  // One-hot decode of a destination register. x0 is never a real write,
  // so it decodes to an empty mask.
  function automatic logic [NUM_REGS-1:0] rd_onehot(
    input logic [REG_ADDR_WIDTH-1:0] rd
  );
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (rd != '0) begin
      mask[rd] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending ALU write requests. Supports push and pop in the
// same cycle and also reports which registers its live entries will write.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  wb_req_t             push_req_i,
  input  logic                pop_i,
  output wb_req_t             head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [NUM_REGS-1:0] rd_mask_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] slot_age;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;

  // Advance pointers modulo DEPTH; count is unchanged when both happen.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only slots inside the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_req_i;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    rd_mask_o = '0;
    slot_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_age = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(slot_age) < count_q) begin
        rd_mask_o = rd_mask_o | rd_onehot(mem_q[i].rd);
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges load and ALU results onto the single register
// file write port. Loads always win; ALU results that lose are queued in
// order and drained when no load is present.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [BUS_DATA_WIDTH-1:0] alu_data,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [BUS_DATA_WIDTH-1:0] ld_data,
  input  logic [1:0]                ld_size,
  input  logic                      ld_unsigned,
  output logic                      write_en,
  output logic [REG_ADDR_WIDTH-1:0] addressC,
  output logic [BUS_DATA_WIDTH-1:0] writeBack,
  output logic [NUM_REGS-1:0]       pending_mask
);

  logic                      write_en_q, write_en_d;
  logic [REG_ADDR_WIDTH-1:0] addressC_q, addressC_d;
  logic [BUS_DATA_WIDTH-1:0] writeBack_q, writeBack_d;

  logic                alu_accept;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  wb_req_t             fifo_head;
  wb_req_t             fifo_in;
  logic [NUM_REGS-1:0] fifo_rd_mask;

  // Readiness depends only on registered occupancy, so a full queue refuses
  // even in a cycle where it is about to drain an entry.
  assign alu_ready  = ~fifo_full;
  assign alu_accept = alu_valid & alu_ready;

  assign fifo_in.rd   = alu_rd;
  assign fifo_in.data = WB_DATA_WIDTH'(alu_data);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_req_i (fifo_in),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .rd_mask_o  (fifo_rd_mask)
  );

  // Arbitrate the write port: load, then queued ALU result, then a fresh ALU
  // result straight through. An accepted ALU result that does not go straight
  // through is queued. Writes to x0 use the slot but never raise write_en.
  always_comb begin
    write_en_d  = 1'b0;
    addressC_d  = addressC_q;
    writeBack_d = writeBack_q;
    fifo_pop    = 1'b0;
    fifo_push   = 1'b0;
    if (ld_valid) begin
      write_en_d  = (ld_rd != '0);
      addressC_d  = ld_rd;
      writeBack_d = BUS_DATA_WIDTH'(extend_load(WB_DATA_WIDTH'(ld_data),
                                                ld_size, ld_unsigned));
      fifo_push   = alu_accept;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      write_en_d  = (fifo_head.rd != '0);
      addressC_d  = fifo_head.rd;
      writeBack_d = BUS_DATA_WIDTH'(fifo_head.data);
      fifo_push   = alu_accept;
    end else if (alu_accept) begin
      write_en_d  = (alu_rd != '0);
      addressC_d  = alu_rd;
      writeBack_d = alu_data;
    end
  end

  // Write port registers; reset discards any write that was about to happen.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en_q  <= 1'b0;
      addressC_q  <= '0;
      writeBack_q <= '0;
    end else begin
      write_en_q  <= write_en_d;
      addressC_q  <= addressC_d;
      writeBack_q <= writeBack_d;
    end
  end

  assign write_en  = write_en_q;
  assign addressC  = addressC_q;
  assign writeBack = writeBack_q;

  // Registers still owed a write: everything queued plus whatever is on the
  // port right now. A bit drops the cycle after its write is presented.
  always_comb begin
    pending_mask = fifo_rd_mask;
    if (write_en_q) begin
      pending_mask = pending_mask | rd_onehot(addressC_q);
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected register
// writes in the order they must appear, a monitor pops on every write_en.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } expWrite_t;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        write_en;
  logic [4:0]  addressC;
  logic [63:0] writeBack;
  logic [31:0] pending_mask;

  expWrite_t expQueue[$];
  int        checks = 0;
  int        errors = 0;

  writeback_unit #(
    .BUS_DATA_WIDTH (64),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_size      (ld_size),
    .ld_unsigned  (ld_unsigned),
    .write_en     (write_en),
    .addressC     (addressC),
    .writeBack    (writeBack),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [63:0] data);
    expWrite_t e;
    e.rd   = rd;
    e.data = data;
    expQueue.push_back(e);
  endtask

  // Drive one cycle of inputs, report whether the ALU offer is taken, and
  // return #1 after the capturing edge.
  task automatic applyStimulus(input bit ldV, input logic [4:0] ldRd,
                               input logic [63:0] ldData, input logic [1:0] ldSize,
                               input bit ldUns, input bit aluV,
                               input logic [4:0] aluRd, input logic [63:0] aluData,
                               output bit aluTaken);
    ld_valid    = ldV;
    ld_rd       = ldRd;
    ld_data     = ldData;
    ld_size     = ldSize;
    ld_unsigned = ldUns;
    alu_valid   = aluV;
    alu_rd      = aluRd;
    alu_data    = aluData;
    aluTaken    = aluV && (alu_ready === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    bit unused;
    applyStimulus(0, 5'd0, 64'd0, 2'd0, 0, 0, 5'd0, 64'd0, unused);
  endtask

  // Monitor: every presented write must be the next expected one.
  always @(negedge clk) begin
    expWrite_t e;
    if (write_en === 1'b1) begin
      if (expQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                 addressC, writeBack);
      end else begin
        e = expQueue.pop_front();
        checkOutput("write_addr", {59'd0, addressC}, {59'd0, e.rd});
        checkOutput("write_data", writeBack, e.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          taken;
    int          aluIdx;
    logic [63:0] sweepData;
    logic [1:0]  sweepSize [8];
    bit          sweepUns  [8];
    logic [63:0] sweepExp  [8];

    reset       = 1'b1;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_size     = '0;
    ld_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_write_en", {63'd0, write_en}, 64'd0);
    checkOutput("reset_addressC", {59'd0, addressC}, 64'd0);
    checkOutput("reset_writeBack", writeBack, 64'd0);
    checkOutput("reset_pending", {32'd0, pending_mask}, 64'd0);
    checkOutput("reset_alu_ready", {63'd0, alu_ready}, 64'd1);

    // Single ALU result goes straight through with one cycle of latency.
    expectWrite(5'd5, 64'h1234);
    applyStimulus(0, 5'd0, 64'd0, 2'd0, 0, 1, 5'd5, 64'h1234, taken);
    checkOutput("alu_direct_pending", {32'd0, pending_mask}, 64'h20);
    checkOutput("alu_direct_we", {63'd0, write_en}, 64'd1);
    idleCycle();
    checkOutput("alu_direct_pending_clear", {32'd0, pending_mask}, 64'd0);

    // Load beats a simultaneous ALU result; the ALU result follows.
    expectWrite(5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    expectWrite(5'd4, 64'h7);
    applyStimulus(1, 5'd3, 64'hFF, 2'b00, 0, 1, 5'd4, 64'h7, taken);
    checkOutput("collide_pending_1", {32'd0, pending_mask}, 64'h18);
    idleCycle();
    checkOutput("collide_pending_2", {32'd0, pending_mask}, 64'h10);
    idleCycle();
    checkOutput("collide_pending_3", {32'd0, pending_mask}, 64'd0);

    // Six loads while the ALU offers r10..r15: the queue fills after four.
    aluIdx = 0;
    for (int cyc = 0; cyc < 40 && aluIdx < 6; cyc++) begin
      if (cyc == 6) begin
        for (int i = 0; i < 6; i++) expectWrite(5'(10 + i), 64'hA000 + 64'(i));
      end
      if (cyc < 6) begin
        checkOutput($sformatf("fill_alu_ready_%0d", cyc), {63'd0, alu_ready},
                    (cyc < 4) ? 64'd1 : 64'd0);
        expectWrite(5'(20 + cyc), 64'h1000 + 64'(cyc));
      end
      applyStimulus(cyc < 6, 5'(20 + cyc), 64'h1000 + 64'(cyc), 2'b11, 0,
                    1, 5'(10 + aluIdx), 64'hA000 + 64'(aluIdx), taken);
      if (taken) aluIdx++;
    end
    checkOutput("fill_all_accepted", 64'(aluIdx), 64'd6);
    repeat (8) idleCycle();
    checkOutput("fill_pending_clear", {32'd0, pending_mask}, 64'd0);

    // Load extension sweep.
    sweepData = 64'h8000_8080_8080_8080;
    sweepSize = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    sweepUns  = '{0, 1, 0, 1, 0, 1, 0, 1};
    sweepExp  = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80,
                  64'hFFFF_FFFF_FFFF_8080, 64'h8080,
                  64'hFFFF_FFFF_8080_8080, 64'h0000_0000_8080_8080,
                  64'h8000_8080_8080_8080, 64'h8000_8080_8080_8080};
    for (int i = 0; i < 8; i++) begin
      expectWrite(5'(6 + i), sweepExp[i]);
      applyStimulus(1, 5'(6 + i), sweepData, sweepSize[i], sweepUns[i],
                    0, 5'd0, 64'd0, taken);
    end
    expectWrite(5'd16, 64'h7F);
    applyStimulus(1, 5'd16, 64'h7F, 2'b00, 0, 0, 5'd0, 64'd0, taken);
    repeat (2) idleCycle();

    // A result for x0 is taken but never written.
    applyStimulus(0, 5'd0, 64'd0, 2'd0, 0, 1, 5'd0, 64'hDEAD, taken);
    checkOutput("x0_accepted", {63'd0, taken}, 64'd1);
    checkOutput("x0_write_en", {63'd0, write_en}, 64'd0);
    checkOutput("x0_pending", {32'd0, pending_mask}, 64'd0);
    idleCycle();
    checkOutput("x0_write_en_after", {63'd0, write_en}, 64'd0);

    // Park three ALU results behind loads, then reset.
    for (int i = 0; i < 3; i++) begin
      expectWrite(5'(21 + i), 64'h2000 + 64'(i));
      applyStimulus(1, 5'(21 + i), 64'h2000 + 64'(i), 2'b11, 0,
                    1, 5'(11 + i), 64'hB000 + 64'(i), taken);
    end
    checkOutput("pre_reset_pending", {32'd0, pending_mask}, 64'h0080_3800);
    reset = 1'b1;
    idleCycle();
    checkOutput("in_reset_write_en", {63'd0, write_en}, 64'd0);
    checkOutput("in_reset_pending", {32'd0, pending_mask}, 64'd0);
    reset = 1'b0;
    idleCycle();
    checkOutput("post_reset_write_en", {63'd0, write_en}, 64'd0);
    checkOutput("post_reset_pending", {32'd0, pending_mask}, 64'd0);
    checkOutput("post_reset_alu_ready", {63'd0, alu_ready}, 64'd1);
    repeat (4) idleCycle();

    checkOutput("scoreboard_drained", 64'(expQueue.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Writeback stage that drives the register file write port (write_en, addressC, writeBack). It merges results from the ALU and the load unit onto that single port. Load results are size/sign-extended and have priority. ALU results that lose arbitration are held in a small in-order FIFO. A per-register pending mask is exported so issue logic can stall on write-after-write and read-after-write hazards to registers not yet written.

Parameters:
BUS_DATA_WIDTH, 64, register/data width in bits
FIFO_DEPTH, 4, ALU result FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  unit can accept an ALU result this cycle
alu_rd  input  5  ALU destination register
alu_data  input  BUS_DATA_WIDTH  ALU result
ld_valid  input  1  load result valid (always accepted, no ready)
ld_rd  input  5  load destination register
ld_data  input  BUS_DATA_WIDTH  load data, right-aligned
ld_size  input  2  00 byte, 01 half, 10 word, 11 double
ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend
write_en  output  1  register file write enable
addressC  output  5  register file write address
writeBack  output  BUS_DATA_WIDTH  register file write data
pending_mask  output  32  bit r set = write to r is queued or on the port

Behaviour:
- Single clock, clk. Synchronous active-high reset.
- All outputs are registered except alu_ready and pending_mask, which are combinational from registered state.
- Reset values: write_en=0, addressC=0, writeBack=0, FIFO empty (count=0), pending_mask=0. alu_ready=1 from the first cycle after reset.
- Reset mid-operation: FIFO contents and any in-flight write are discarded. No write_en is asserted in the cycle after reset is released unless a new result was accepted in that cycle.
- Handshakes:
  - ALU accept = alu_valid & alu_ready.
  - alu_ready = (count != FIFO_DEPTH). It is based on registered count, so a full FIFO refuses even in a cycle where it dequeues.
  - A load is accepted whenever ld_valid=1.
- Per-cycle priority (selects the source of next-cycle write_en/addressC/writeBack):
  1. ld_valid → extended load result.
  2. Else FIFO not empty → FIFO head, dequeued.
  3. Else ALU accept → alu_rd/alu_data directly, bypassing the FIFO.
  4. Else write_en=0 next cycle; addressC/writeBack hold their previous values.
- Enqueue rule: an accepted ALU result is enqueued unless it took path 3. Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- Latency:
  - Load: accepted in cycle N → write_en in N+1.
  - ALU with FIFO empty and no load: N → N+1.
  - Otherwise the ALU result waits behind the load stream and earlier FIFO entries.
  - ALU results always write in acceptance order.
- Load starvation: continuous loads starve the FIFO. This is allowed; the load unit cannot issue back-to-back for more than 8 cycles.
- x0 handling: a result with rd=0 is accepted and consumes its arbitration slot, but write_en stays 0 for that slot. rd=0 never sets pending_mask.
- Load extension:
  - Take the low 8/16/32/64 bits of ld_data according to ld_size.
  - Fill the upper bits with zero (ld_unsigned=1) or with the copy of the top bit taken (ld_unsigned=0).
  - For double, ld_unsigned is ignored.
- pending_mask: OR of the decoded rd of every valid FIFO entry and of addressC when write_en=1. It reflects registered state, and a bit clears in the cycle after the write_en that retires it.
- Hazard ownership: issue logic uses pending_mask to avoid two in-flight writes to the same rd. The unit does no ordering between load and ALU writes to the same register.
- FIFO pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared package wb_pkg holds:
  - ld_size encodings (LD_BYTE, LD_HALF, LD_WORD, LD_DOUBLE);
  - REG_ADDR_WIDTH=5 and NUM_REGS=32;
  - packed struct wb_req_t {rd, data}.
- One sub-module is natural: wb_fifo, a synchronous FIFO of wb_req_t with full/empty/count and same-cycle push/pop.
- Load extension is a function in wb_pkg, not a module.

Test Plan:
- Reset then a single ALU result (rd=5, data=0x1234) with no load → write_en=1, addressC=5, writeBack=0x1234 one cycle later; pending_mask bit 5 is set for exactly that cycle.
- ld_valid and alu_valid in the same cycle (ld rd=3, 0xFF, byte, signed; alu rd=4, 0x7) → cycle+1 writes r3=0xFFFF_FFFF_FFFF_FFFF; cycle+2 writes r4=0x7.
- 6 consecutive cycles of loads while ALU presents rd=10..15 → alu_ready drops after 4 accepts. After the loads stop, r10..r13 are written in order, then r14 and r15.
- Load extension sweep on ld_data=0x8000_8080_8080_8080:
  - half unsigned → 0x8080;
  - word signed → 0xFFFF_FFFF_8080_8080;
  - double → unchanged.
- ALU result with rd=0 and data=0xDEAD → slot consumed, write_en stays 0, pending_mask stays 0.
- Reset asserted while the FIFO holds 3 entries → after release no write_en, count=0, alu_ready=1, pending_mask=0.
